// File: rtl/vine_sweeper_pkg.sv
// Shared definitions for the vine sweeper game: opcodes, error codes,
// ASCII command characters, parser state encoding and a coordinate check.
package vine_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_ROW = 2'd1,
    ST_GET_COL = 2'd2,
    ST_HOLD    = 2'd3
  } parser_state_t;

  localparam logic [1:0] OP_OPEN    = 2'd0;
  localparam logic [1:0] OP_FLAG    = 2'd1;
  localparam logic [1:0] OP_RESTART = 2'd2;

  localparam logic [1:0] ERR_BAD_OP    = 2'd0;
  localparam logic [1:0] ERR_BAD_COORD = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN   = 2'd3;

  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // True when b is an ASCII decimal digit whose value is below limit.
  function automatic logic coord_ok(input logic [7:0] b, input logic [7:0] limit);
    logic [7:0] d;
    d = b - ASCII_0;
    return (b >= ASCII_0) && (b <= ASCII_9) && (d < limit);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_frame_timer.sv
// Loadable down-counter used as the inter-byte timeout of a command frame.
// The counter stops at zero; expired is high whenever it reads zero.
module frame_timer #(
  parameter int LOAD_VALUE = 299,
  parameter int CNT_W      = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Load takes priority over counting; counting halts at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LOAD_VALUE);
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into OPEN / FLAG / RESTART commands for the board
// controller, validates them, enforces an inter-byte timeout and reports
// errors with a one-cycle strobe, a sticky code and a saturating count.
module uart_cmd_parser
  import vine_sweeper_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int COORD_W        = 4,
  parameter int TIMEOUT_CLOCKS = 300
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rxdata,
  input  logic               rxfinish,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [COORD_W-1:0] cmd_row,
  output logic [COORD_W-1:0] cmd_col,
  output logic               err_pulse,
  output logic [1:0]         err_code,
  output logic [7:0]         err_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CLOCKS + 1);

  parser_state_t state;
  logic [7:0]    digit;
  logic          is_op_byte;
  logic          is_blank;
  logic          row_ok;
  logic          col_ok;
  logic          timer_load;
  logic          timer_en;
  logic          timer_expired;
  logic          err_now;
  logic [1:0]    err_kind;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign digit      = rxdata - ASCII_0;
  assign is_op_byte = (rxdata == ASCII_O) || (rxdata == ASCII_F);
  assign is_blank   = (rxdata == ASCII_SP) || (rxdata == ASCII_CR) || (rxdata == ASCII_LF);
  assign row_ok     = coord_ok(rxdata, 8'(ROWS));
  assign col_ok     = coord_ok(rxdata, 8'(COLS));

  // The timer restarts on every accepted byte that leaves the frame open.
  assign timer_load = rxfinish && (((state == ST_IDLE) && is_op_byte) ||
                                   ((state == ST_GET_ROW) && row_ok));
  assign timer_en   = (state == ST_GET_ROW) || (state == ST_GET_COL);

  frame_timer #(
    .LOAD_VALUE (TIMEOUT_CLOCKS - 1),
    .CNT_W      (TMR_W)
  ) u_frame_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Error detection; a byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    err_now  = 1'b0;
    err_kind = ERR_BAD_OP;
    unique case (state)
      ST_IDLE: begin
        if (rxfinish && !is_op_byte && (rxdata != ASCII_R) && !is_blank) begin
          err_now  = 1'b1;
          err_kind = ERR_BAD_OP;
        end
      end
      ST_GET_ROW, ST_GET_COL: begin
        if (rxfinish) begin
          if (((state == ST_GET_ROW) && !row_ok) || ((state == ST_GET_COL) && !col_ok)) begin
            err_now  = 1'b1;
            err_kind = ERR_BAD_COORD;
          end
        end else if (timer_expired) begin
          err_now  = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (rxfinish) begin
          err_now  = 1'b1;
          err_kind = ERR_OVERRUN;
        end
      end
      default: ;
    endcase
  end

  // Parser FSM with registered command and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= err_now;
      if (err_now) begin
        err_code  <= err_kind;
        err_count <= sat_inc(err_count);
      end

      unique case (state)
        ST_IDLE: begin
          if (rxfinish) begin
            if (rxdata == ASCII_O) begin
              cmd_op <= OP_OPEN;
              state  <= ST_GET_ROW;
            end else if (rxdata == ASCII_F) begin
              cmd_op <= OP_FLAG;
              state  <= ST_GET_ROW;
            end else if (rxdata == ASCII_R) begin
              cmd_op    <= OP_RESTART;
              cmd_row   <= '0;
              cmd_col   <= '0;
              cmd_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_GET_ROW: begin
          if (rxfinish) begin
            if (row_ok) begin
              cmd_row <= digit[COORD_W-1:0];
              state   <= ST_GET_COL;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timer_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_COL: begin
          if (rxfinish) begin
            if (col_ok) begin
              cmd_col   <= digit[COORD_W-1:0];
              cmd_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timer_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sequences the byte stream from the UART receiver into game commands for the board controller. Consumes the receiver's byte strobe and frames 1- or 3-byte ASCII commands: open cell, flag cell, restart. Validates opcodes and coordinates, enforces an inter-byte timeout, and presents each command on a valid/ready handshake. Sits between the UART receiver and the game state machine.

Parameters:
ROWS, 8, board rows; legal range 1..10.
COLS, 8, board columns; legal range 1..10.
COORD_W, 4, width of the cmd_row and cmd_col outputs.
TIMEOUT_CLOCKS, 300, maximum number of clocks between bytes of one frame (about 3 byte times at clockperbit=10).

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
rxdata  input  8  received byte; sampled only when rxfinish=1
rxfinish  input  1  one-cycle strobe, new byte on rxdata
cmd_valid  output  1  command available
cmd_ready  input  1  consumer accepts the command
cmd_op  output  2  0=OPEN, 1=FLAG, 2=RESTART
cmd_row  output  COORD_W  row index
cmd_col  output  COORD_W  column index
err_pulse  output  1  one-cycle error strobe
err_code  output  2  0=BAD_OP, 1=BAD_COORD, 2=TIMEOUT, 3=OVERRUN; holds the last error
err_count  output  8  saturating error count

Behaviour:
- Reset: state IDLE. All outputs 0. Timer cleared.
- Byte events: state logic acts only on cycles where rxfinish=1. rxdata is ignored on all other cycles.
- IDLE:
  - 'O' (0x4F) or 'F' (0x46): latch op, go to GET_ROW, load timer with TIMEOUT_CLOCKS-1.
  - 'R' (0x52): op=RESTART, row=0, col=0, go to HOLD.
  - 0x20, 0x0D, 0x0A: ignored with no error.
  - Any other byte: BAD_OP error; stay in IDLE.
- GET_ROW:
  - Byte in '0'..'9' with value < ROWS: latch row, go to GET_COL, reload timer.
  - Any other byte: BAD_COORD error, go to IDLE.
- GET_COL:
  - Same rule as GET_ROW, checked against COLS.
  - Valid byte: latch col, go to HOLD.
  - Invalid byte: BAD_COORD error, go to IDLE.
- Timer (GET_ROW and GET_COL only):
  - Decrements each cycle.
  - At 0 with no rxfinish: TIMEOUT error, go to IDLE, discard the partial frame.
  - rxfinish in the same cycle the timer reaches 0: the byte is processed and no timeout is raised.
- HOLD:
  - cmd_valid=1. cmd_op, cmd_row and cmd_col stay stable until the handshake.
  - cmd_valid && cmd_ready: go to IDLE; cmd_valid=0 on the next cycle.
  - rxfinish in HOLD, including the handshake cycle: byte dropped, OVERRUN error.
- Latency: cmd_valid rises on the cycle after the rxfinish of the final byte (col byte, or 'R').
- Errors:
  - err_pulse is high for exactly one cycle; err_code updates on the same edge.
  - err_count increments per error and saturates at 255.
  - At most one error per cycle.
- cmd_row and cmd_col hold the binary value, zero-extended to COORD_W.
- Reset mid-frame or in HOLD: returns to IDLE on the next edge, the frame is lost, no error is raised.

Decomposition:
- Shared package vine_sweeper_pkg holds:
  - opcode constants OP_OPEN, OP_FLAG, OP_RESTART;
  - error code constants;
  - ASCII constants for 'O', 'F', 'R', '0', space, CR, LF;
  - parser state encoding.
- One natural sub-module: frame_timer, a loadable down-counter with an expiry flag.

Test Plan:
- Bytes 'O','3','5', cmd_ready=1 -> cmd_valid pulse one cycle after the '5' strobe; op=0, row=3, col=5; no error.
- 'R' with cmd_ready=0 for 20 cycles, then 1 -> cmd_valid held 21 cycles with op=2, row=0, col=0; drops on the cycle after the handshake.
- 'F','9' with ROWS=8 -> err_pulse, err_code=1, err_count=1, state IDLE. Then 'F','1','2' -> op=1, row=1, col=2.
- 'O' then no byte for 300 clocks -> err_code=2 exactly TIMEOUT_CLOCKS cycles after the 'O' strobe. Same with '4' arriving on the expiry cycle -> no error, frame continues.
- Command held with cmd_ready=0, 'O' arrives -> err_code=3; command unchanged. 'X' in IDLE -> err_code=0. Space/CR/LF in IDLE -> no error.
- 300 consecutive 'X' bytes -> err_count saturates at 255. Reset asserted during GET_COL -> outputs 0, IDLE, no err_pulse.
